// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing FSM for the UART receiver: line synchroniser, start/parity/stop checking.
// Optional saturating frame-error counter enabled by defining UART_RX_ERR_CNT_EN.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     rx_clk,
    input  logic                     rst,
    input  logic                     rx_in,
    input  logic                     par_en,
    input  logic                     par_typ,
    input  logic                     edge_done_tick,
    input  logic                     data_done_tick,
    input  logic                     sampled_bit,
`ifdef UART_RX_ERR_CNT_EN
    input  logic                     err_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
`endif
    output logic                     counter_enable,
    output logic                     sampler_enable,
    output logic                     deserializer_enable,
    output logic                     busy,
    output logic                     data_valid,
    output logic                     parity_error,
    output logic                     stop_error,
    output logic                     start_glitch
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    generate
        if (DATA_WIDTH < 1 || ERR_CNT_WIDTH < 1) begin : g_param_check
            $error("uart_rx_ctrl: DATA_WIDTH and ERR_CNT_WIDTH must be positive");
        end
    endgenerate

    logic       rx_meta_q, rx_s_q;
    logic [2:0] state_q, state_d;
    logic       par_en_q, par_en_d;
    logic       par_typ_q, par_typ_d;
    logic       acc_q, acc_d;
    logic       parity_error_q, parity_error_d;
    logic       stop_error_q, stop_error_d;
    logic       data_valid_q, data_valid_d;
    logic       start_glitch_q, start_glitch_d;

    always_comb begin
        state_d        = state_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        acc_d          = acc_q;
        parity_error_d = parity_error_q;
        stop_error_d   = stop_error_q;
        data_valid_d   = 1'b0;
        start_glitch_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Parity config is frozen for the whole frame at start detection
                if (!rx_s_q) begin
                    state_d        = START;
                    par_en_d       = par_en;
                    par_typ_d      = par_typ;
                    acc_d          = 1'b0;
                    parity_error_d = 1'b0;
                    stop_error_d   = 1'b0;
                end
            end
            START: begin
                if (edge_done_tick) begin
                    if (sampled_bit) begin
                        state_d        = IDLE;
                        start_glitch_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (edge_done_tick) begin
                    acc_d = acc_q ^ sampled_bit;
                    if (data_done_tick) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (edge_done_tick) begin
                    parity_error_d = sampled_bit != (acc_q ^ par_typ_q);
                    state_d        = STOP;
                end
            end
            STOP: begin
                if (edge_done_tick) begin
                    stop_error_d = ~sampled_bit;
                    data_valid_d = sampled_bit & ~parity_error_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            rx_meta_q      <= 1'b1;
            rx_s_q         <= 1'b1;
            state_q        <= IDLE;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            acc_q          <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            data_valid_q   <= 1'b0;
            start_glitch_q <= 1'b0;
        end else begin
            rx_meta_q      <= rx_in;
            rx_s_q         <= rx_meta_q;
            state_q        <= state_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            acc_q          <= acc_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
            data_valid_q   <= data_valid_d;
            start_glitch_q <= start_glitch_d;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic                     err_inc;
    logic [ERR_CNT_WIDTH-1:0] err_count_q;

    assign err_inc = start_glitch_d | (parity_error_d & ~parity_error_q)
                   | (stop_error_d & ~stop_error_q);

    // Clear has priority over a coincident increment; count sticks at all-ones
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (err_clr) begin
            err_count_q <= '0;
        end else if (err_inc && (err_count_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_count_q <= err_count_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign err_count = err_count_q;
`endif

    assign counter_enable      = (state_q != IDLE);
    assign sampler_enable      = (state_q != IDLE);
    assign busy                = (state_q != IDLE);
    assign deserializer_enable = (state_q == DATA);
    assign data_valid          = data_valid_q;
    assign parity_error        = parity_error_q;
    assign stop_error          = stop_error_q;
    assign start_glitch        = start_glitch_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: models counter/sampler/deserializer at prescale 8 and predicts
// the output waveform from frame timing arithmetic. Covers err_count when UART_RX_ERR_CNT_EN is set.
module tb_uart_rx_ctrl;
    localparam int MAXC = 16000;

    logic rx_clk = 1'b0;
    logic rst = 1'b0;
    logic rx_in = 1'b1;
    logic par_en = 1'b0;
    logic par_typ = 1'b0;
    logic edge_done_tick, data_done_tick, sampled_bit;
    logic counter_enable, sampler_enable, deserializer_enable, busy;
    logic data_valid, parity_error, stop_error, start_glitch;
`ifdef UART_RX_ERR_CNT_EN
    logic       err_clr = 1'b0;
    logic [7:0] err_count;
`endif

    uart_rx_ctrl #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) dut (
        .rx_clk(rx_clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
        .edge_done_tick(edge_done_tick), .data_done_tick(data_done_tick), .sampled_bit(sampled_bit),
`ifdef UART_RX_ERR_CNT_EN
        .err_clr(err_clr), .err_count(err_count),
`endif
        .counter_enable(counter_enable), .sampler_enable(sampler_enable),
        .deserializer_enable(deserializer_enable), .busy(busy), .data_valid(data_valid),
        .parity_error(parity_error), .stop_error(stop_error), .start_glitch(start_glitch)
    );

    always #5 rx_clk = ~rx_clk;

    // Companion blocks: edge/bit counter, mid-bit sampler, deserializer
    logic [2:0] ecnt_q = 3'd0;
    logic [2:0] bcnt_q = 3'd0;
    logic       samp_q = 1'b1;
    logic [7:0] sr_q = 8'h00;
    int         cyc = 0;

    always @(posedge rx_clk) begin
        cyc <= cyc + 1;
        ecnt_q <= counter_enable ? ecnt_q + 3'd1 : 3'd0;
        if (counter_enable && ecnt_q == 3'd3) samp_q <= rx_in;
        if (!deserializer_enable) bcnt_q <= 3'd0;
        else if (edge_done_tick) bcnt_q <= bcnt_q + 3'd1;
        if (deserializer_enable && edge_done_tick) sr_q <= {sampled_bit, sr_q[7:1]};
    end

    assign edge_done_tick = counter_enable && (ecnt_q == 3'd7);
    assign data_done_tick = deserializer_enable && (bcnt_q == 3'd7);
    assign sampled_bit    = samp_q;

    // Predicted waveform, indexed by number of rising edges seen
    bit e_busy[MAXC];
    bit e_den[MAXC];
    bit e_dv[MAXC];
    bit e_gl[MAXC];
    bit inc_ev[MAXC];
    bit clr_ev[MAXC];
    int pe_ev[MAXC];
    int se_ev[MAXC];

    bit   m_pe = 1'b0, m_se = 1'b0, check_en = 1'b0;
    int   m_ec = 0;
    int   chk_cnt = 0, pass_cnt = 0;
    int   dv_cnt = 0, gl_cnt = 0, den_cnt = 0;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] act_v, exp_v;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge rx_clk) begin
        if (rst) begin
            m_pe = 1'b0;
            m_se = 1'b0;
            m_ec = 0;
        end else if (cyc < MAXC) begin
            if (pe_ev[cyc] >= 0) m_pe = (pe_ev[cyc] != 0);
            if (se_ev[cyc] >= 0) m_se = (se_ev[cyc] != 0);
            if (clr_ev[cyc]) m_ec = 0;
            else if (inc_ev[cyc] && m_ec < 255) m_ec++;
            if (check_en) begin
                exp_v = {e_busy[cyc], e_busy[cyc], e_busy[cyc], e_den[cyc], e_dv[cyc], m_pe, m_se, e_gl[cyc]};
                act_v = {busy, counter_enable, sampler_enable, deserializer_enable,
                         data_valid, parity_error, stop_error, start_glitch};
                chk_cnt++;
                if (act_v == exp_v) pass_cnt++;
                else $display("FAIL cycle %0d outputs: got %b expected %b", cyc, act_v, exp_v);
`ifdef UART_RX_ERR_CNT_EN
                chk_cnt++;
                if (err_count == 8'(m_ec)) pass_cnt++;
                else $display("FAIL cycle %0d err_count: got %0d expected %0d", cyc, err_count, m_ec);
`endif
            end
        end
        if (data_valid) begin
            dv_cnt++;
            last_byte = sr_q;
        end
        if (start_glitch) gl_cnt++;
        if (deserializer_enable) den_cnt++;
    end

    task automatic mark(input int n, input int what, input int val);
        if (n >= 0 && n < MAXC) begin
            case (what)
                0: e_busy[n] = 1'b1;
                1: e_den[n]  = 1'b1;
                2: e_dv[n]   = (val != 0);
                3: e_gl[n]   = 1'b1;
                4: pe_ev[n]  = val;
                5: se_ev[n]  = val;
                6: inc_ev[n] = 1'b1;
                default: clr_ev[n] = (val != 0);
            endcase
        end
    endtask

    // Start bit falls just before edge n1; bit k is consumed at edge n1+10+8k
    task automatic send_frame(input logic [7:0] data, input bit pon, input bit typ,
                              input bit bad, input bit stopb);
        logic [10:0] bits;
        int nb, n1, last;
        @(negedge rx_clk);
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = data;
        if (pon) begin
            bits[9] = (^data) ^ typ ^ bad;
            bits[10] = stopb;
            nb = 11;
        end else begin
            bits[9] = stopb;
            nb = 10;
        end
        n1 = cyc + 1;
        last = n1 + 2 + 8 * nb;
        for (int n = n1 + 2; n < last; n++) mark(n, 0, 1);
        for (int n = n1 + 10; n < n1 + 74; n++) mark(n, 1, 1);
        mark(n1 + 2, 4, 0);
        mark(n1 + 2, 5, 0);
        if (pon) begin
            mark(n1 + 82, 4, int'(bad));
            if (bad) mark(n1 + 82, 6, 1);
        end
        mark(last, 5, int'(!stopb));
        if (!stopb) mark(last, 6, 1);
        mark(last, 2, int'(stopb && !(pon && bad)));
        par_en = pon;
        par_typ = typ;
        for (int i = 0; i < nb; i++) begin
            rx_in = bits[i];
            if (i == 2) begin
                par_en = ~pon;
                par_typ = ~typ;
            end
            repeat (8) @(negedge rx_clk);
        end
        rx_in = 1'b1;
        par_en = pon;
        par_typ = typ;
        repeat (6) @(negedge rx_clk);
    endtask

    task automatic glitch(input bit clr);
        int n1;
        @(negedge rx_clk);
        n1 = cyc + 1;
        for (int n = n1 + 2; n < n1 + 10; n++) mark(n, 0, 1);
        mark(n1 + 2, 4, 0);
        mark(n1 + 2, 5, 0);
        mark(n1 + 10, 3, 1);
        mark(n1 + 10, 6, 1);
        mark(n1 + 10, 7, int'(clr));
        rx_in = 1'b0;
        repeat (2) @(negedge rx_clk);
        rx_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
`ifdef UART_RX_ERR_CNT_EN
            err_clr = clr && (cyc + 1 == n1 + 10);
`endif
            @(negedge rx_clk);
        end
`ifdef UART_RX_ERR_CNT_EN
        err_clr = 1'b0;
`endif
    endtask

    initial begin
        int d0, g0;
        for (int i = 0; i < MAXC; i++) begin
            pe_ev[i] = -1;
            se_ev[i] = -1;
        end
        #2 rst = 1'b1;
        #1 check("reset_outputs", {busy, counter_enable, sampler_enable, deserializer_enable,
                                   data_valid, parity_error, stop_error, start_glitch}, 0);
`ifdef UART_RX_ERR_CNT_EN
        check("reset_err_count", err_count, 0);
`endif
        repeat (3) @(negedge rx_clk);
        rst = 1'b0;
        check_en = 1'b1;
        repeat (4) @(negedge rx_clk);

        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        check("good55_dv_count", dv_cnt, 1);
        check("good55_byte", last_byte, 8'h55);
        check("good55_parity_error", parity_error, 0);
        check("good55_stop_error", stop_error, 0);
        check("good55_busy", busy, 0);

        send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
        check("badpar_parity_error", parity_error, 1);
        check("badpar_dv_count", dv_cnt, 1);

        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stoperr_stop_error", stop_error, 1);
        check("stoperr_parity_cleared", parity_error, 0);
        check("stoperr_dv_count", dv_cnt, 1);
        check("stoperr_busy", busy, 0);

        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
        check("recover_stop_error", stop_error, 0);
        check("recover_byte", last_byte, 8'h3C);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
        check("oddpar_dv_count", dv_cnt, 3);
        check("oddpar_parity_error", parity_error, 0);

        d0 = den_cnt;
        g0 = gl_cnt;
        glitch(1'b0);
        check("glitch_pulses", gl_cnt - g0, 1);
        check("glitch_no_deser", den_cnt - d0, 0);
        check("glitch_busy", busy, 0);

        check_en = 1'b0;
        @(negedge rx_clk);
        rx_in = 1'b0;
        repeat (8) @(negedge rx_clk);
        rx_in = 1'b0;
        repeat (8) @(negedge rx_clk);
        rx_in = 1'b1;
        repeat (8) @(negedge rx_clk);
        rx_in = 1'b0;
        repeat (8) @(negedge rx_clk);
        rx_in = 1'b1;
        repeat (4) @(negedge rx_clk);
        check("abort_in_data", deserializer_enable, 1);
        @(posedge rx_clk);
        #2 rst = 1'b1;
        #1 check("abort_outputs", {busy, counter_enable, sampler_enable, deserializer_enable,
                                   data_valid, parity_error, stop_error, start_glitch}, 0);
        repeat (2) @(negedge rx_clk);
        rst = 1'b0;
        repeat (20) @(negedge rx_clk);
        check("abort_no_dv", dv_cnt, 3);
        check_en = 1'b1;
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
        check("after_abort_dv_count", dv_cnt, 4);
        check("after_abort_byte", last_byte, 8'h0F);

`ifdef UART_RX_ERR_CNT_EN
        check("errcnt_start", err_count, 0);
        for (int i = 0; i < 3; i++) send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
        check("errcnt_three", err_count, 3);
        for (int i = 0; i < 300; i++) glitch(1'b0);
        check("errcnt_saturate", err_count, 255);
        glitch(1'b1);
        check("errcnt_clear_wins", err_count, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
